// File: rtl/cvt_dw_seq.sv
// cvt_dw_seq: multi-cycle conversion between a 32-bit signed word and an
// IEEE-754 double (CVT.D.W and CVT.W.D). A bit-serial shifter normalises
// (word -> double) or aligns (double -> word) one bit per cycle, so the
// conversion takes a data-dependent number of cycles behind a start/done
// handshake, with busy asserted while the shifter is working.
module cvt_dw_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [63:0] din,
  output logic        busy,
  output logic        done,
  output logic [63:0] dout,
  output logic        invalid,
  output logic        inexact
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NORM  = 3'd1,
    S_ALIGN = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Magnitude of a signed word; the most negative value maps onto itself,
  // which is exactly the 2^31 magnitude the normaliser needs.
  function automatic logic [31:0] abs_word(input logic signed [31:0] w);
    return w[31] ? -w : w;
  endfunction

  // Round-to-nearest, ties-to-even on the aligned integer part.
  function automatic logic [31:0] rne_mag(input logic [31:0] trunc,
                                          input logic        rbit,
                                          input logic        sticky);
    return trunc + {31'b0, rbit & (sticky | trunc[0])};
  endfunction

  state_t      state_q, state_d;
  logic [63:0] dout_q, dout_d;
  logic        inv_q, inv_d;
  logic        inx_q, inx_d;

  // Working datapath: m is the shifter (53 bits for the double mantissa,
  // low 32 bits for the word magnitude), r/s are round and sticky bits.
  logic        sign_q, sign_d;
  logic [52:0] m_q, m_d;
  logic [10:0] exp_q, exp_d;
  logic        r_q, r_d;
  logic        s_q, s_d;
  logic [5:0]  cnt_q, cnt_d;

  logic [10:0] e_in;
  logic [31:0] rnd_mag;

  assign e_in = din[62:52];

  // Next-state, datapath and result computation.
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    inv_d   = inv_q;
    inx_d   = inx_q;
    sign_d  = sign_q;
    m_d     = m_q;
    exp_d   = exp_q;
    r_d     = r_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    rnd_mag = rne_mag(m_q[31:0], r_q, s_q);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          inv_d   = 1'b0;
          inx_d   = 1'b0;
          state_d = S_DONE;
          if (!op) begin
            if (din[31:0] == 32'd0) begin
              dout_d = 64'd0;
            end else begin
              sign_d  = din[31];
              m_d     = {21'b0, abs_word(din[31:0])};
              exp_d   = 11'd1054;
              state_d = S_NORM;
            end
          end else if (din == 64'hC1E0_0000_0000_0000) begin
            // -2^31 is representable even though its exponent is out of range.
            dout_d = {32'b0, 32'h8000_0000};
          end else if (e_in == 11'h7FF || e_in >= 11'd1054) begin
            dout_d = {32'b0, 32'h7FFF_FFFF};
            inv_d  = 1'b1;
          end else if (e_in < 11'd1022) begin
            // |x| < 0.5 always rounds to zero; any nonzero bit makes it inexact.
            dout_d = 64'd0;
            inx_d  = |din[62:0];
          end else begin
            sign_d  = din[63];
            m_d     = {1'b1, din[51:0]};
            r_d     = 1'b0;
            s_d     = 1'b0;
            cnt_d   = 6'(11'd1075 - e_in);
            state_d = S_ALIGN;
          end
        end
      end

      S_NORM: begin
        if (m_q[31]) begin
          dout_d  = {sign_q, exp_q, m_q[30:0], 21'b0};
          state_d = S_DONE;
        end else begin
          m_d   = {m_q[51:0], 1'b0};
          exp_d = exp_q - 11'd1;
        end
      end

      S_ALIGN: begin
        s_d   = s_q | r_q;
        r_d   = m_q[0];
        m_d   = {1'b0, m_q[52:1]};
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = S_ROUND;
      end

      S_ROUND: begin
        if (!sign_q && rnd_mag == 32'h8000_0000) begin
          dout_d = {32'b0, 32'h7FFF_FFFF};
          inv_d  = 1'b1;
        end else begin
          dout_d = {32'b0, sign_q ? -rnd_mag : rnd_mag};
          inx_d  = r_q | s_q;
        end
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and visible result registers; reset aborts any conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dout_q  <= 64'd0;
      inv_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      inv_q   <= inv_d;
      inx_q   <= inx_d;
    end
  end

  // Shifter datapath; its contents are only meaningful after a launch.
  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    m_q    <= m_d;
    exp_q  <= exp_d;
    r_q    <= r_d;
    s_q    <= s_d;
    cnt_q  <= cnt_d;
  end

  assign busy    = (state_q == S_NORM) || (state_q == S_ALIGN) || (state_q == S_ROUND);
  assign done    = (state_q == S_DONE);
  assign dout    = dout_q;
  assign invalid = inv_q;
  assign inexact = inx_q;

endmodule
